// File: rtl/pipelined_processor.sv
// 5-stage in-order MIPS-subset CPU (IF/ID/EX/MEM/WB) with internal program ROM,
// data RAM, register file, operand forwarding, load-use stall and predict-not-taken beq.

module pp_pc (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] pc
);
  logic [31:0] PCOut;
  logic [31:0] pc_d;

  // A taken branch overrides a load-use hold.
  always_comb begin
    pc_d = PCOut + 32'd4;
    if (redirect) begin
      pc_d = target;
    end else if (stall) begin
      pc_d = PCOut;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PCOut <= '0;
    end else begin
      PCOut <= pc_d;
    end
  end

  assign pc = PCOut;
endmodule

module pp_ifid (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc_plus4,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4
);
  logic [31:0] ID_Instruction;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4_q;
  logic [31:0] pc_plus4_d;

  always_comb begin
    instr_d    = ID_Instruction;
    pc_plus4_d = pc_plus4_q;
    if (flush) begin
      instr_d    = '0;
      pc_plus4_d = '0;
    end else if (!stall) begin
      instr_d    = if_instr;
      pc_plus4_d = if_pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ID_Instruction <= '0;
      pc_plus4_q     <= '0;
    end else begin
      ID_Instruction <= instr_d;
      pc_plus4_q     <= pc_plus4_d;
    end
  end

  assign instr    = ID_Instruction;
  assign pc_plus4 = pc_plus4_q;
endmodule

module pp_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rs_data_c,
  output logic [31:0] rt_data_c
);
  logic [31:0] registers [0:31];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        registers[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      registers[wa] <= wd;
    end
  end

  // Write-through so ID sees the value WB is committing this cycle.
  always_comb begin
    rs_data_c = registers[rs_addr];
    rt_data_c = registers[rt_addr];
    if (we && (wa == rs_addr)) rs_data_c = wd;
    if (we && (wa == rt_addr)) rt_data_c = wd;
    if (rs_addr == 5'd0) rs_data_c = '0;
    if (rt_addr == 5'd0) rt_data_c = '0;
  end
endmodule

module pipelined_processor #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 64
) (
  input logic clk,
  input logic reset
);
  localparam int unsigned DMEM_AW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc_plus4;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
  } idex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  dst;
  } exmem_t;

  typedef struct packed {
    logic        reg_write;
    logic [31:0] result;
    logic [4:0]  dst;
  } memwb_t;

  function automatic logic [31:0] rom_word(input logic [5:0] idx);
    logic [31:0] w;
    case (idx)
      6'd0:    w = 32'h2001_0005; // addi r1,r0,5
      6'd1:    w = 32'h2002_000A; // addi r2,r0,10
      6'd2:    w = 32'h0022_1820; // add  r3,r1,r2
      6'd3:    w = 32'h0041_2022; // sub  r4,r2,r1
      6'd4:    w = 32'h0022_2824; // and  r5,r1,r2
      6'd5:    w = 32'h0022_3025; // or   r6,r1,r2
      6'd6:    w = 32'hAC03_0000; // sw   r3,0(r0)
      6'd7:    w = 32'h8C07_0000; // lw   r7,0(r0)
      6'd8:    w = 32'h00E1_4020; // add  r8,r7,r1
      6'd9:    w = 32'h1024_0001; // beq  r1,r4,+1
      6'd10:   w = 32'h2009_0001; // addi r9,r0,1
      6'd11:   w = 32'h2009_0002; // addi r9,r0,2
      default: w = '0;
    endcase
    if (32'(idx) >= IMEM_DEPTH) w = '0;
    return w;
  endfunction

  function automatic ctrl_t decode(input logic [31:0] ins);
    ctrl_t c;
    c = '0;
    case (ins[31:26])
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        case (ins[5:0])
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: c.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_LW: begin
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_BEQ:  c.branch = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  logic [31:0] if_pc, if_instr_c, if_pc_plus4_c;
  logic [31:0] id_instr, id_pc_plus4;
  logic [31:0] rs_data_c, rt_data_c;
  ctrl_t       id_ctrl_c;
  logic [4:0]  id_dst_c;
  logic        load_use_c, branch_taken_c, exmem_fwd_c, memwb_fwd_c;
  logic [31:0] branch_target_c, fwd_a_c, fwd_b_c, op_b_c, alu_c, mem_rdata_c;
  logic [DMEM_AW-1:0] dmem_idx_c;
  idex_t       idex_q, idex_d;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;
  logic [31:0] dmem [0:DMEM_DEPTH-1];

  pp_pc pc_module (
    .clk      (clk),
    .reset    (reset),
    .stall    (load_use_c),
    .redirect (branch_taken_c),
    .target   (branch_target_c),
    .pc       (if_pc)
  );

  assign if_pc_plus4_c = if_pc + 32'd4;
  assign if_instr_c    = rom_word(if_pc[7:2]);

  pp_ifid ifid (
    .clk         (clk),
    .reset       (reset),
    .stall       (load_use_c),
    .flush       (branch_taken_c),
    .if_instr    (if_instr_c),
    .if_pc_plus4 (if_pc_plus4_c),
    .instr       (id_instr),
    .pc_plus4    (id_pc_plus4)
  );

  pp_regfile regfile (
    .clk       (clk),
    .reset     (reset),
    .rs_addr   (id_instr[25:21]),
    .rt_addr   (id_instr[20:16]),
    .we        (memwb_q.reg_write),
    .wa        (memwb_q.dst),
    .wd        (memwb_q.result),
    .rs_data_c (rs_data_c),
    .rt_data_c (rt_data_c)
  );

  // ID: decode, load-use detection, bubble on stall or branch flush.
  always_comb begin
    id_ctrl_c  = decode(id_instr);
    id_dst_c   = (id_instr[31:26] == OP_RTYPE) ? id_instr[15:11] : id_instr[20:16];
    load_use_c = idex_q.ctrl.mem_read &&
                 ((idex_q.rt == id_instr[25:21]) || (idex_q.rt == id_instr[20:16]));
    idex_d     = '0;
    if (!branch_taken_c && !load_use_c) begin
      idex_d.ctrl     = id_ctrl_c;
      idex_d.pc_plus4 = id_pc_plus4;
      idex_d.rs_val   = rs_data_c;
      idex_d.rt_val   = rt_data_c;
      idex_d.imm      = {{16{id_instr[15]}}, id_instr[15:0]};
      idex_d.rs       = id_instr[25:21];
      idex_d.rt       = id_instr[20:16];
      idex_d.dst      = id_dst_c;
    end
  end

  // EX: forwarding (EX/MEM first), ALU, branch resolution.
  always_comb begin
    exmem_fwd_c = exmem_q.reg_write && !exmem_q.mem_read && (exmem_q.dst != 5'd0);
    memwb_fwd_c = memwb_q.reg_write && (memwb_q.dst != 5'd0);

    fwd_a_c = idex_q.rs_val;
    if (exmem_fwd_c && (exmem_q.dst == idex_q.rs)) fwd_a_c = exmem_q.alu_res;
    else if (memwb_fwd_c && (memwb_q.dst == idex_q.rs)) fwd_a_c = memwb_q.result;

    fwd_b_c = idex_q.rt_val;
    if (exmem_fwd_c && (exmem_q.dst == idex_q.rt)) fwd_b_c = exmem_q.alu_res;
    else if (memwb_fwd_c && (memwb_q.dst == idex_q.rt)) fwd_b_c = memwb_q.result;

    op_b_c = idex_q.ctrl.alu_src ? idex_q.imm : fwd_b_c;
    case (idex_q.ctrl.alu_op)
      ALU_SUB: alu_c = fwd_a_c - op_b_c;
      ALU_AND: alu_c = fwd_a_c & op_b_c;
      ALU_OR:  alu_c = fwd_a_c | op_b_c;
      ALU_SLT: alu_c = {31'd0, ($signed(fwd_a_c) < $signed(op_b_c))};
      default: alu_c = fwd_a_c + op_b_c;
    endcase

    branch_taken_c  = idex_q.ctrl.branch && (fwd_a_c == fwd_b_c);
    branch_target_c = idex_q.pc_plus4 + {idex_q.imm[29:0], 2'b00};

    exmem_d.reg_write  = idex_q.ctrl.reg_write;
    exmem_d.mem_read   = idex_q.ctrl.mem_read;
    exmem_d.mem_write  = idex_q.ctrl.mem_write;
    exmem_d.alu_res    = alu_c;
    exmem_d.store_data = fwd_b_c;
    exmem_d.dst        = idex_q.dst;
  end

  // MEM: combinational load read; WB value selected here.
  always_comb begin
    dmem_idx_c        = exmem_q.alu_res[DMEM_AW+1:2];
    mem_rdata_c       = dmem[dmem_idx_c];
    memwb_d.reg_write = exmem_q.reg_write;
    memwb_d.result    = exmem_q.mem_read ? mem_rdata_c : exmem_q.alu_res;
    memwb_d.dst       = exmem_q.dst;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DMEM_DEPTH); i++) begin
        dmem[i] <= '0;
      end
    end else if (exmem_q.mem_write) begin
      dmem[dmem_idx_c] <= exmem_q.store_data;
    end
  end
endmodule

// File: tb/tb_pipelined_processor.sv
// Self-checking bench for pipelined_processor: PC trace scoreboard, hazard
// corner checks and final register-file table, with reset applied twice.

module tb_pipelined_processor;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  pipelined_processor dut (
    .clk   (clk),
    .reset (reset)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    int          idx;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t    final_tbl[9];
  logic [31:0] exp_pc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] get_reg(input int i);
    return dut.regfile.registers[i];
  endfunction

  // Expected PC after the k-th edge following reset release: one load-use
  // hold at edge 10, branch redirect to 0x2C at edge 13.
  function automatic logic [31:0] model_pc(input int k);
    if (k <= 9)       return 32'(4 * k);
    else if (k == 10) return 32'd36;
    else if (k == 11) return 32'd40;
    else if (k <= 13) return 32'd44;
    else              return 32'(4 * (k - 2));
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_pc"}, dut.pc_module.PCOut, 32'd0);
    check({tag, "_ifid"}, dut.ifid.ID_Instruction, 32'd0);
    for (int i = 1; i <= 9; i++) begin
      check($sformatf("%s_r%0d", tag, i), get_reg(i), 32'd0);
    end
    check({tag, "_dmem0"}, dut.dmem[0], 32'd0);
  endtask

  task automatic check_final(input string tag);
    for (int i = 0; i < 9; i++) begin
      check({tag, "_", final_tbl[i].name}, get_reg(final_tbl[i].idx), final_tbl[i].exp);
    end
  endtask

  task automatic run_cycles(input int n);
    logic [31:0] exp_pc;
    for (int k = 1; k <= n; k++) begin
      exp_pc_q.push_back(model_pc(k));
      @(posedge clk);
      #1;
      exp_pc = exp_pc_q.pop_front();
      check($sformatf("pc_c%0d", k), dut.pc_module.PCOut, exp_pc);
      check($sformatf("r9_not_1_c%0d", k), {31'd0, (get_reg(9) == 32'd1)}, 32'd0);
      case (k)
        6:  check("raw_r3_before_wb", get_reg(3), 32'd0);
        7:  check("raw_r3_exmem_fwd", get_reg(3), 32'd15);
        8:  check("ifid_lw", dut.ifid.ID_Instruction, 32'h8C07_0000);
        10: check("ifid_held_add", dut.ifid.ID_Instruction, 32'h00E1_4020);
        13: begin
          check("ifid_flushed", dut.ifid.ID_Instruction, 32'd0);
          check("r8_not_yet", get_reg(8), 32'd0);
        end
        14: begin
          check("r8_load_use", get_reg(8), 32'd20);
          check("ifid_after_branch", dut.ifid.ID_Instruction, 32'h2009_0002);
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    final_tbl[0] = '{"r1", 1, 32'd5};
    final_tbl[1] = '{"r2", 2, 32'd10};
    final_tbl[2] = '{"r3", 3, 32'd15};
    final_tbl[3] = '{"r4", 4, 32'd5};
    final_tbl[4] = '{"r5", 5, 32'd0};
    final_tbl[5] = '{"r6", 6, 32'd15};
    final_tbl[6] = '{"r7", 7, 32'd15};
    final_tbl[7] = '{"r8", 8, 32'd20};
    final_tbl[8] = '{"r9", 9, 32'd2};

    // Reset held for two cycles.
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("rst_init");

    reset = 1'b0;
    run_cycles(20);
    check_final("run1");
    check("run1_dmem0", dut.dmem[0], 32'd15);

    // Reset after a complete run clears regs, pipeline and RAM.
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero("rst_end");

    // Mid-program reset at cycle 8, then rerun to completion.
    reset = 1'b0;
    run_cycles(8);
    check("mid_r4_before_rst", get_reg(4), 32'd5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero("rst_mid");

    reset = 1'b0;
    run_cycles(20);
    check_final("run2");
    check("run2_dmem0", dut.dmem[0], 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
